wback_stage_pipe: RTL
=====================

# wback_stage_pipe

Parametrised MEM→WB pipeline register and writeback unit for the core, sitting between the memory stage and the register file / CSR file. It registers the memory-stage bundle once per accepted instruction and supports stall and flush. It aligns and sign- or zero-extends load data, and selects one of four register-writeback sources. It guarantees single-shot register, CSR and retire side effects under stall, and maintains the retired-instruction counter.

## Interface
Parameters:
- XLEN, 32: datapath width, 32 or 64.
- REG_ADDR_W, 5: register index width.
- CSR_ADDR_W, 12: CSR address width.
- CNT_W, 64: retire counter width.
- OFF_W, $clog2(XLEN/8): load byte-offset width (derived).

Ports:
- Clock and reset: reset rst, synchronous, active-high; clock clk.
- clk  in  1  clock.
- rst  in  1  reset.
- validM  in  1  M-stage bundle holds a real instruction.
- stallW  in  1  hold W-stage contents.
- flushW  in  1  kill W-stage contents.
- regSrcM  in  2  rd source: 00 ALU, 01 MEM, 10 PC+4, 11 CSR old value.
- loadFnM  in  3  load funct3.
- byteOffM  in  OFF_W  load address low bits.
- regWriteM, csrWriteM  in  1  write enables.
- rdAddrM  in  REG_ADDR_W  destination register.
- csrAddrM  in  CSR_ADDR_W  destination CSR.
- aluResultM, readDataM, pcPlus4M, csrResultM, csrOldM  in  XLEN  operands.
- cntWrite  in  1  software write of the retire counter.
- cntWdata  in  CNT_W  value for that write.
- validW  out  1  W holds a live instruction.
- regWrite, csrWrite  out  1  single-shot write strobes.
- rdAddr  out  REG_ADDR_W  register-file write address.
- csrAddr  out  CSR_ADDR_W  CSR-file write address.
- regResult, csrResult  out  XLEN  write data.
- retire  out  1  single-shot retire pulse.
- instret  out  CNT_W  retired-instruction count.

## Operation
- Register update priority is rst > flushW > stallW > load.
- rst clears every held field, validW, the done bit and instret.
- flushW clears validW and done; payload fields are don't-care.
- stallW holds all fields.
- Otherwise, every field loads from its M input, validW loads validM, and done clears.
- Done bit: set at the end of any cycle in which validW=1 and stallW=1. It makes strobes fire only in the first W cycle of an instruction.
- regWrite = validW & regWriteSv & rdAddr≠0 & ~done.
- csrWrite = validW & csrWriteSv & ~done.
- retire = validW & ~done.
- rdAddr, csrAddr and csrResult are driven directly from the held fields.
- regResult mux: 00 aluResult; 01 load data; 10 pcPlus4; 11 csrOld.
- Load data:
  - sh = readData >> (8·byteOff), with zeros shifted in.
  - LB (000) and LH (001) sign-extend bits 7 and 15.
  - LW (010) sign-extends bit 31 when XLEN=64; it is a plain pass when XLEN=32.
  - LD (011) passes all XLEN bits.
  - LBU (100), LHU (101) and LWU (110) zero-extend.
  - 011 and 110 are legal only when XLEN=64; otherwise, and for 111, the result is 0.
- Misalignment is trapped upstream; it is not checked here.
- instret:
  - cntWrite has priority: instret ← cntWdata and that cycle's retire is not counted.
  - Else, on retire, instret ← instret+1 mod 2^CNT_W.
  - flushW in the same cycle does not cancel a retire already asserted.

## Timing
- M→W latency is 1 cycle: inputs sampled at edge k appear on held fields after edge k.
- regResult and the strobes are combinational from held state; there is no extra cycle.
- instret reflects a retire on the edge ending the retire cycle.
- Reset values: validW=0; regWrite=csrWrite=retire=0; all addresses and data 0; regResult=0 (ALU source, zero operand); instret=0.
- Stall of N cycles: the strobes are high in cycle 1 only; the data outputs are stable for all N+1 cycles.
- A flush while stalled kills the instruction. If its strobes already fired, they are not repeated.
- rst mid-stall clears everything on the next edge.

## Test plan
- Reset, then load ALU bundle (validM=1, regSrc=00, rd=5, alu=0x1234): next cycle regWrite=1, rdAddr=5, regResult=0x1234, retire=1, instret=1.
- Load byte tests, readData=0x80FF7F01: byteOff=2 with LB gives 0xFFFFFFFF; LBU gives 0x000000FF; byteOff=2 with LH gives 0xFFFF80FF; LHU at offset 0 gives 0x00007F01.
- regSrc=11, csrOld=0xA5, csrWrite=1, csrResult=0x5A: regResult=0xA5, csrWrite=1 with csrResult=0x5A, both for one cycle only.
- Hold stallW for 3 cycles with a live instruction: regWrite, csrWrite and retire pulse once; instret increments by exactly 1; outputs stay stable.
- rd=0 with regWrite=1: regWrite stays 0 and retire=1. flushW with validM=1: validW=0 and no strobes.
- instret=0xFFFF…F then retire: instret wraps to 0. cntWrite=1, cntWdata=100 together with retire: instret=100.

Source files
------------

// File: rtl/wback_stage_pipe.sv
// MEM->WB pipeline register and writeback unit: holds the memory-stage bundle,
// aligns/extends load data, selects the rd source and issues single-shot strobes.
module wback_stage_pipe #(
  parameter int XLEN       = 32,
  parameter int REG_ADDR_W = 5,
  parameter int CSR_ADDR_W = 12,
  parameter int CNT_W      = 64,
  parameter int OFF_W      = $clog2(XLEN/8)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  validM,
  input  logic                  stallW,
  input  logic                  flushW,
  input  logic [1:0]            regSrcM,
  input  logic [2:0]            loadFnM,
  input  logic [OFF_W-1:0]      byteOffM,
  input  logic                  regWriteM,
  input  logic                  csrWriteM,
  input  logic [REG_ADDR_W-1:0] rdAddrM,
  input  logic [CSR_ADDR_W-1:0] csrAddrM,
  input  logic [XLEN-1:0]       aluResultM,
  input  logic [XLEN-1:0]       readDataM,
  input  logic [XLEN-1:0]       pcPlus4M,
  input  logic [XLEN-1:0]       csrResultM,
  input  logic [XLEN-1:0]       csrOldM,
  input  logic                  cntWrite,
  input  logic [CNT_W-1:0]      cntWdata,
  output logic                  validW,
  output logic                  regWrite,
  output logic                  csrWrite,
  output logic [REG_ADDR_W-1:0] rdAddr,
  output logic [CSR_ADDR_W-1:0] csrAddr,
  output logic [XLEN-1:0]       regResult,
  output logic [XLEN-1:0]       csrResult,
  output logic                  retire,
  output logic [CNT_W-1:0]      instret
);

  logic                  valid_reg;
  logic                  done_reg;
  logic [1:0]            regsrc_reg;
  logic [2:0]            loadfn_reg;
  logic [OFF_W-1:0]      byteoff_reg;
  logic                  regwrite_reg;
  logic                  csrwrite_reg;
  logic [REG_ADDR_W-1:0] rdaddr_reg;
  logic [CSR_ADDR_W-1:0] csraddr_reg;
  logic [XLEN-1:0]       alu_reg;
  logic [XLEN-1:0]       rdata_reg;
  logic [XLEN-1:0]       pc4_reg;
  logic [XLEN-1:0]       csrres_reg;
  logic [XLEN-1:0]       csrold_reg;
  logic [CNT_W-1:0]      instret_reg;
  logic [CNT_W-1:0]      instret_next;

  // Flush leaves the payload untouched; only valid/done matter once killed.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_reg    <= 1'b0;
      done_reg     <= 1'b0;
      regsrc_reg   <= '0;
      loadfn_reg   <= '0;
      byteoff_reg  <= '0;
      regwrite_reg <= 1'b0;
      csrwrite_reg <= 1'b0;
      rdaddr_reg   <= '0;
      csraddr_reg  <= '0;
      alu_reg      <= '0;
      rdata_reg    <= '0;
      pc4_reg      <= '0;
      csrres_reg   <= '0;
      csrold_reg   <= '0;
    end else if (flushW) begin
      valid_reg <= 1'b0;
      done_reg  <= 1'b0;
    end else if (stallW) begin
      done_reg <= done_reg | valid_reg;
    end else begin
      valid_reg    <= validM;
      done_reg     <= 1'b0;
      regsrc_reg   <= regSrcM;
      loadfn_reg   <= loadFnM;
      byteoff_reg  <= byteOffM;
      regwrite_reg <= regWriteM;
      csrwrite_reg <= csrWriteM;
      rdaddr_reg   <= rdAddrM;
      csraddr_reg  <= csrAddrM;
      alu_reg      <= aluResultM;
      rdata_reg    <= readDataM;
      pc4_reg      <= pcPlus4M;
      csrres_reg   <= csrResultM;
      csrold_reg   <= csrOldM;
    end
  end

  assign validW   = valid_reg;
  assign retire   = valid_reg & ~done_reg;
  assign regWrite = valid_reg & regwrite_reg & (rdaddr_reg != '0) & ~done_reg;
  assign csrWrite = valid_reg & csrwrite_reg & ~done_reg;
  assign rdAddr   = rdaddr_reg;
  assign csrAddr  = csraddr_reg;
  assign csrResult = csrres_reg;

  logic [XLEN-1:0] sh;
  logic [XLEN-1:0] lw_val;
  logic [XLEN-1:0] ld_val;
  logic [XLEN-1:0] lwu_val;
  logic [XLEN-1:0] load_data;

  assign sh = rdata_reg >> {byteoff_reg, 3'b000};

  // Word-sized forms differ between RV32 and RV64.
  generate
    if (XLEN == 64) begin : g_rv64
      assign lw_val  = {{(XLEN-32){sh[31]}}, sh[31:0]};
      assign ld_val  = sh;
      assign lwu_val = {{(XLEN-32){1'b0}}, sh[31:0]};
    end else begin : g_rv32
      assign lw_val  = sh;
      assign ld_val  = '0;
      assign lwu_val = '0;
    end
  endgenerate

  always_comb begin
    load_data = '0;
    case (loadfn_reg)
      3'b000:  load_data = {{(XLEN-8){sh[7]}}, sh[7:0]};
      3'b001:  load_data = {{(XLEN-16){sh[15]}}, sh[15:0]};
      3'b010:  load_data = lw_val;
      3'b011:  load_data = ld_val;
      3'b100:  load_data = {{(XLEN-8){1'b0}}, sh[7:0]};
      3'b101:  load_data = {{(XLEN-16){1'b0}}, sh[15:0]};
      3'b110:  load_data = lwu_val;
      default: load_data = '0;
    endcase
  end

  always_comb begin
    regResult = alu_reg;
    case (regsrc_reg)
      2'b00:   regResult = alu_reg;
      2'b01:   regResult = load_data;
      2'b10:   regResult = pc4_reg;
      default: regResult = csrold_reg;
    endcase
  end

  // Software write wins; the retire of that cycle is deliberately dropped.
  always_comb begin
    instret_next = instret_reg;
    if (cntWrite)
      instret_next = cntWdata;
    else if (retire)
      instret_next = instret_reg + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst)
      instret_reg <= '0;
    else
      instret_reg <= instret_next;
  end

  assign instret = instret_reg;

endmodule
